// File: rtl/bp_update_queue.sv
// In-order branch tracking queue feeding the bimodal predictor's training port.
// Emits a registered BHT update and a one-cycle mispredict pulse per resolve.
module bp_update_queue #(
  parameter  int DEPTH = 8,
  parameter  int PC_W  = 14,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [PC_W-1:0]  push_pc,
  input  logic             push_pred,
  output logic             push_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             res_ready,
  input  logic             flush_in,
  output logic             upd_valid,
  output logic [PC_W-1:0]  upd_pc,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] count
);

  logic [PC_W:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               upd_valid_q;
  logic [PC_W-1:0]    upd_pc_q;
  logic               upd_taken_q;
  logic               mis_q;

  logic               empty, full;
  logic               res_acc, mis_now, push_acc;
  logic [PC_W-1:0]    head_pc;
  logic               head_pred;

  always_comb begin
    empty      = (cnt_q == '0);
    full       = (cnt_q == CNT_W'(DEPTH));
    head_pc    = mem_q[rd_ptr_q][PC_W:1];
    head_pred  = mem_q[rd_ptr_q][0];
    res_acc    = res_valid && !empty;
    mis_now    = res_acc && (head_pred != res_taken);
    push_ready = !full && !mis_now;
    res_ready  = !empty;
    push_acc   = push_valid && push_ready && !flush_in;
  end

  // Flush and mispredict both leave the queue empty; a same-cycle push is lost.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_in) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else if (mis_now) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      wr_ptr_d = rd_ptr_q + 1'b1;
      cnt_d    = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (res_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push_acc) - CNT_W'(res_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= {push_pc, push_pred};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      upd_valid_q <= res_acc;
      mis_q       <= mis_now;
      if (res_acc) begin
        upd_pc_q    <= head_pc;
        upd_taken_q <= res_taken;
      end
    end
  end

  assign upd_valid  = upd_valid_q;
  assign upd_pc     = upd_pc_q;
  assign upd_taken  = upd_taken_q;
  assign mispredict = mis_q;
  assign count      = cnt_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// Directed and random checks of bp_update_queue against a queue-based model.
// The model tracks entries as a list of {pc, pred}.
module tb_bp_update_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 14;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            pred;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_valid;
  logic [PC_W-1:0]  push_pc;
  logic             push_pred;
  logic             push_ready;
  logic             res_valid;
  logic             res_taken;
  logic             res_ready;
  logic             flush_in;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic             mispredict;
  logic [CNT_W-1:0] count;

  int total = 0;
  int bad   = 0;
  ent_t model[$];

  bp_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pc(push_pc),
    .push_pred(push_pred), .push_ready(push_ready),
    .res_valid(res_valid), .res_taken(res_taken),
    .res_ready(res_ready), .flush_in(flush_in),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .mispredict(mispredict),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    push_valid = 1'b0;
    push_pc    = '0;
    push_pred  = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    flush_in   = 1'b0;
  endtask

  // One clock: drive, check ready/count, step model, check registered outputs.
  task automatic step(input logic pv, input logic [PC_W-1:0] pc,
                      input logic pp, input logic rv,
                      input logic rt, input logic fl);
    logic racc, mis, pr, pacc;
    ent_t head, e;
    push_valid = pv;
    push_pc    = pc;
    push_pred  = pp;
    res_valid  = rv;
    res_taken  = rt;
    flush_in   = fl;
    #1;
    racc = rv && (model.size() > 0);
    head.pc = '0;
    head.pred = 1'b0;
    if (racc) head = model[0];
    mis  = racc && (head.pred != rt);
    pr   = (model.size() < DEPTH) && !mis;
    pacc = pv && pr && !fl;
    chk("push_ready", 32'(push_ready), 32'(pr));
    chk("res_ready", 32'(res_ready), 32'(model.size() > 0));
    chk("count_pre", 32'(count), 32'(model.size()));
    if (racc) void'(model.pop_front());
    if (fl || mis) begin
      model.delete();
    end else if (pacc) begin
      e.pc = pc;
      e.pred = pp;
      model.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("upd_valid", 32'(upd_valid), 32'(racc));
    chk("mispredict", 32'(mispredict), 32'(mis));
    chk("count_post", 32'(count), 32'(model.size()));
    if (racc) begin
      chk("upd_pc", 32'(upd_pc), 32'(head.pc));
      chk("upd_taken", 32'(upd_taken), 32'(rt));
    end
  endtask

  initial begin
    logic [PC_W-1:0] pcs [3];
    logic            tk  [3];
    idle();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_res_ready", 32'(res_ready), 0);
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_upd_pc", 32'(upd_pc), 0);
    chk("rst_upd_taken", 32'(upd_taken), 0);
    chk("rst_mispredict", 32'(mispredict), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Three pushes, then resolve in order
    pcs[0] = 14'h010; pcs[1] = 14'h020; pcs[2] = 14'h030;
    tk[0] = 1'b1; tk[1] = 1'b0; tk[2] = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, pcs[i], tk[i], 1'b0, 1'b0, 1'b0);
    chk("t1_count", 32'(count), 3);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, tk[i], 1'b0);

    // Fill to DEPTH, overflow push, resolve+push while full
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, PC_W'(14'h100 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 14'h3ff, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 14'h3fe, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_count", 32'(count), DEPTH - 1);
    while (model.size() > 0) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Mispredict with same-cycle push
    step(1'b1, 14'h040, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++)
      step(1'b1, PC_W'(14'h040 + i), 1'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 14'h0aa, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t4_count", 32'(count), 0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Flush with same-cycle correct resolve
    for (int i = 0; i < 5; i++)
      step(1'b1, PC_W'(14'h200 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 14'h2ff, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_count", 32'(count), 0);

    // Wrap-around push/resolve pairs
    for (int i = 0; i < 20; i++) begin
      logic p;
      p = 1'($urandom_range(0, 1));
      step(1'b1, PC_W'($urandom), p, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, p, 1'b0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), PC_W'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 31) == 0));

    // Asynchronous reset mid-stream right after an update
    for (int i = 0; i < 3; i++)
      step(1'b1, PC_W'(14'h300 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    #1;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_upd_valid", 32'(upd_valid), 0);
    chk("arst_mispredict", 32'(mispredict), 0);
    chk("arst_res_ready", 32'(res_ready), 0);
    model.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 14'h155, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
